// File: rtl/x25519_squeeze_arbiter_if.sv
// Bundles the requester handshakes, the squeeze-unit issue/return path and the
// result bus. slave is the arbiter's view; master is the surrounding system's view.
interface x25519_squeeze_arbiter_if;
    logic         req0_valid;
    logic [263:0] req0_a;
    logic         req0_ready;
    logic         req1_valid;
    logic [263:0] req1_a;
    logic         req1_ready;
    logic         sq_en;
    logic [263:0] sq_a;
    logic         sq_out_valid;
    logic [263:0] sq_out;
    logic         out_valid0;
    logic         out_valid1;
    logic [263:0] out;
    logic         tag_err;

    modport slave (
        input  req0_valid, req0_a, req1_valid, req1_a, sq_out_valid, sq_out,
        output req0_ready, req1_ready, sq_en, sq_a, out_valid0, out_valid1, out, tag_err
    );

    modport master (
        output req0_valid, req0_a, req1_valid, req1_a, sq_out_valid, sq_out,
        input  req0_ready, req1_ready, sq_en, sq_a, out_valid0, out_valid1, out, tag_err
    );
endinterface

// File: rtl/x25519_squeeze_arbiter.sv
// Round-robin arbiter sharing one fixed-latency X25519 squeeze unit between two
// requesters; a tag pipeline routes each returning result and flags mismatches.
module x25519_squeeze_arbiter #(
    parameter int unsigned LATENCY = 3
) (
    input logic                      clk,
    input logic                      rst,
    x25519_squeeze_arbiter_if.slave  bus
);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {DRAIN, RUN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        drain_cnt_q, drain_cnt_d;
    logic                 last_q;
    logic                 gnt0, gnt1, issue;
    logic [263:0]         gnt_a;
    logic                 sq_en_q, sq_id_q;
    logic [263:0]         sq_a_q;
    logic [LATENCY-1:0]   tag_v_q, tag_v_d, tag_id_q, tag_id_d;
    logic                 tail_v, tail_id, in_run, hit, miss;
    logic                 out_valid0_q, out_valid1_q, tag_err_q;
    logic [263:0]         out_q;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        if (state_q == DRAIN) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (drain_cnt_q == CW'(LATENCY - 1)) begin
                state_d     = RUN;
                drain_cnt_d = '0;
            end
        end else if (bus.req0_valid && bus.req1_valid) begin
            // last_q = 1 means requester 1 won most recently, so requester 0 is due
            gnt0 = last_q;
            gnt1 = !last_q;
        end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
        end
    end

    assign issue = gnt0 | gnt1;
    assign gnt_a = gnt1 ? bus.req1_a : bus.req0_a;

    // Entry 0 takes the registered issue, so the tail lines up with sq_out_valid.
    always_comb begin
        tag_v_d     = tag_v_q;
        tag_id_d    = tag_id_q;
        tag_v_d[0]  = sq_en_q;
        tag_id_d[0] = sq_id_q;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    assign tail_v  = tag_v_q[LATENCY-1];
    assign tail_id = tag_id_q[LATENCY-1];
    assign in_run  = (state_q == RUN);
    assign hit     = in_run & tail_v & bus.sq_out_valid;
    assign miss    = in_run & (tail_v ^ bus.sq_out_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DRAIN;
            drain_cnt_q  <= '0;
            last_q       <= 1'b1;
            sq_en_q      <= 1'b0;
            sq_id_q      <= 1'b0;
            sq_a_q       <= '0;
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            out_valid0_q <= 1'b0;
            out_valid1_q <= 1'b0;
            out_q        <= '0;
            tag_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            sq_en_q      <= issue;
            if (issue) begin
                sq_a_q  <= gnt_a;
                sq_id_q <= gnt1;
                last_q  <= gnt1;
            end
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            out_valid0_q <= hit & ~tail_id;
            out_valid1_q <= hit & tail_id;
            if (hit) begin
                out_q <= bus.sq_out;
            end
            if (miss) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.sq_en      = sq_en_q;
    assign bus.sq_a       = sq_a_q;
    assign bus.out_valid0 = out_valid0_q;
    assign bus.out_valid1 = out_valid1_q;
    assign bus.out        = out_q;
    assign bus.tag_err    = tag_err_q;
endmodule

// File: tb/tb_x25519_squeeze_arbiter.sv
// Directed bench for x25519_squeeze_arbiter with a behavioural fixed-latency
// squeeze unit (reduces operands >= 2^255-19 by adding 2^256 - p).
module tb_x25519_squeeze_arbiter;
    localparam int unsigned LAT = 3;
    localparam logic [263:0] P   = (264'd1 << 255) - 264'd19;
    localparam logic [263:0] A30 = 264'h7dba22bb1548e333af1bacaa0911643b795e5a14641c1e1f6448cbca3ae9f705;
    localparam logic [263:0] E30 = 264'h007dba22bb1548e333af1bacaa0911643b795e5a14641c1e1f6448cbca3ae9f705;
    localparam logic [263:0] A32 = 264'hdc21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a516967;
    localparam logic [263:0] E32 = 264'h015c21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a51697a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inject = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    x25519_squeeze_arbiter_if bus ();

    x25519_squeeze_arbiter #(.LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [263:0] squeeze(input logic [263:0] a);
        if (a >= P) return a + (264'd1 << 255) + 264'd19;
        return a;
    endfunction

    // Squeeze unit model: not reset, so in-flight results survive an arbiter reset.
    logic [LAT-1:0] pv = '0;
    logic [263:0]   pd [LAT];
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], bus.sq_en};
        pd[0] <= squeeze(bus.sq_a);
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
    assign bus.sq_out_valid = pv[LAT-1] | inject;
    assign bus.sq_out       = pd[LAT-1];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [263:0] obs, input logic [263:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [263:0] ops0 [3];
    logic [263:0] ops1 [3];
    int i0, i1;

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a     = '0;
        bus.req1_a     = '0;
        ops0 = '{264'h0123, P, {8'h00, {256{1'b1}}}};
        ops1 = '{264'h0abc, P - 264'd1, 264'd1 << 255};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkw("rst_out", bus.out, '0);
        chk1("rst_ov0", bus.out_valid0, 1'b0);
        chk1("rst_ov1", bus.out_valid1, 1'b0);
        chk1("rst_err", bus.tag_err, 1'b0);
        chk1("rst_sq_en", bus.sq_en, 1'b0);

        // Single req0, held through DRAIN
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_a     = A30;
        for (int i = 0; i < int'(LAT); i++) begin
            #1;
            chk1("drain_rdy0", bus.req0_ready, 1'b0);
            chk1("drain_sq_en", bus.sq_en, 1'b0);
            @(negedge clk);
        end
        #1;
        chk1("r0_rdy0", bus.req0_ready, 1'b1);
        chk1("r0_rdy1", bus.req1_ready, 1'b0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        chk1("r0_sq_en", bus.sq_en, 1'b1);
        chkw("r0_sq_a", bus.sq_a, A30);
        repeat (3) begin
            @(negedge clk);
            chk1("r0_early_ov0", bus.out_valid0, 1'b0);
        end
        @(negedge clk);
        chk1("r0_ov0", bus.out_valid0, 1'b1);
        chk1("r0_ov1", bus.out_valid1, 1'b0);
        chkw("r0_out", bus.out, E30);
        @(negedge clk);
        chk1("r0_ov0_drop", bus.out_valid0, 1'b0);
        chkw("r0_out_hold", bus.out, E30);

        // req1 only
        bus.req1_valid = 1'b1;
        bus.req1_a     = A32;
        #1;
        chk1("r1_rdy1", bus.req1_ready, 1'b1);
        chk1("r1_rdy0", bus.req0_ready, 1'b0);
        repeat (4) begin
            @(negedge clk);
            bus.req1_valid = 1'b0;
            chk1("r1_early_ov0", bus.out_valid0, 1'b0);
            chk1("r1_early_ov1", bus.out_valid1, 1'b0);
        end
        @(negedge clk);
        chk1("r1_ov1", bus.out_valid1, 1'b1);
        chk1("r1_ov0", bus.out_valid0, 1'b0);
        chkw("r1_out", bus.out, E32);

        // Both valid for 6 cycles: alternate 0,1,0,1,0,1 (req1 won last)
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 6) begin
                bus.req0_valid = 1'b1;
                bus.req1_valid = 1'b1;
                bus.req0_a     = ops0[i0];
                bus.req1_a     = ops1[i1];
            end else begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            if (k >= 5) begin
                chk1("rr_ov0", bus.out_valid0, ((k - 5) % 2) == 0);
                chk1("rr_ov1", bus.out_valid1, ((k - 5) % 2) == 1);
                chkw("rr_out", bus.out,
                     squeeze((((k - 5) % 2) == 0) ? ops0[(k - 5) / 2] : ops1[(k - 5) / 2]));
            end
            #1;
            if (k < 6) begin
                chk1("rr_rdy0", bus.req0_ready, (k % 2) == 0);
                chk1("rr_rdy1", bus.req1_ready, (k % 2) == 1);
                if ((k % 2) == 0) i0++;
                else i1++;
            end
        end
        @(negedge clk);
        chk1("rr_idle_ov0", bus.out_valid0, 1'b0);
        chk1("rr_idle_ov1", bus.out_valid1, 1'b0);
        chk1("rr_err", bus.tag_err, 1'b0);

        // Three ops in flight, then a one-cycle reset
        for (int j = 0; j < 3; j++) begin
            bus.req0_valid = 1'b1;
            bus.req0_a     = 264'd5 + 264'(j);
            #1;
            chk1("fl_rdy0", bus.req0_ready, 1'b1);
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_a     = 264'h1234_5678;
        chkw("fl_rst_out", bus.out, '0);
        for (int j = 0; j < int'(LAT); j++) begin
            chk1("fl_ov0", bus.out_valid0, 1'b0);
            chk1("fl_ov1", bus.out_valid1, 1'b0);
            chk1("fl_err", bus.tag_err, 1'b0);
            #1;
            chk1("fl_drain_rdy0", bus.req0_ready, 1'b0);
            @(negedge clk);
        end
        #1;
        chk1("fl_next_rdy0", bus.req0_ready, 1'b1);
        repeat (4) begin
            @(negedge clk);
            bus.req0_valid = 1'b0;
            chk1("fl_quiet_ov0", bus.out_valid0, 1'b0);
            chk1("fl_quiet_ov1", bus.out_valid1, 1'b0);
            chk1("fl_quiet_err", bus.tag_err, 1'b0);
        end
        @(negedge clk);
        chk1("fl_next_ov0", bus.out_valid0, 1'b1);
        chkw("fl_next_out", bus.out, 264'h1234_5678);

        // Spurious result with an empty tag tail
        @(negedge clk);
        chk1("sp_err_before", bus.tag_err, 1'b0);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        chk1("sp_err", bus.tag_err, 1'b1);
        chk1("sp_ov0", bus.out_valid0, 1'b0);
        chk1("sp_ov1", bus.out_valid1, 1'b0);
        repeat (3) @(negedge clk);
        chk1("sp_err_sticky", bus.tag_err, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("sp_err_cleared", bus.tag_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/x25519_squeeze_arbiter.md
X25519_SQUEEZE_ARBITER -- requirements
Module: X25519_SqueezeArbiter

Interface
REQ-001 Parameter LATENCY, default 3: cycles from sq_en asserted to the matching sq_out_valid of the shared X25519_Squeeze unit.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 operand valid.
REQ-005 req0_a  input  264  requester 0 operand.
REQ-006 req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-007 req1_valid  input  1  requester 1 operand valid.
REQ-008 req1_a  input  264  requester 1 operand.
REQ-009 req1_ready  output  1  requester 1 operand accepted this cycle.
REQ-010 sq_en  output  1  issue strobe to the squeeze unit.
REQ-011 sq_a  output  264  operand to the squeeze unit.
REQ-012 sq_out_valid  input  1  squeeze result valid.
REQ-013 sq_out  input  264  squeeze result.
REQ-014 out_valid0 / out_valid1  output  1 each  result belongs to requester 0 / 1.
REQ-015 out  output  264  registered result bus shared by both requesters.
REQ-016 tag_err  output  1  sticky: result/tag mismatch detected.

Function
REQ-017 FSM states: DRAIN (post-reset flush) and RUN; DRAIN lasts exactly LATENCY cycles, then RUN.
REQ-018 In DRAIN: req0_ready=req1_ready=sq_en=0; any sq_out_valid ignored, no out_valid, no tag_err.
REQ-019 In RUN, at most one grant per cycle; sq_en=1 with sq_a equal to the granted operand in the same cycle, registered (sq_en/sq_a update on the edge after valid is sampled).
REQ-020 Arbitration round-robin: if only one requester valid, it wins; if both, winner is the one not granted last; last-grant pointer resets to 1 (requester 0 wins first tie).
REQ-021 reqN_ready is a combinational pulse asserted in the cycle reqN_valid is sampled and granted; requester holds valid/a until ready.
REQ-022 Throughput: one issue per cycle sustained; the unit has no backpressure, so no stall exists.
REQ-023 Tag pipeline: LATENCY-entry shift register of {valid, id}; entry 0 loaded with {sq_en, granted id} on each issue, advanced every cycle.
REQ-024 When tag tail valid and sq_out_valid: out<=sq_out, out_validN<=1 for tail id, next cycle (total request-to-result latency LATENCY+2 cycles).
REQ-025 Tail valid XOR sq_out_valid in RUN sets tag_err; the result is dropped; tag_err clears only on rst.
REQ-026 out_valid0 and out_valid1 never asserted together; out holds last value when neither is valid.
REQ-027 Results return to each requester in issue order.

Reset
REQ-028 rst sampled high: state<=DRAIN, drain counter<=0, tag pipeline cleared, sq_en<=0, out_valid0/1<=0, tag_err<=0, out<=0, last-grant pointer<=1.
REQ-029 rst mid-operation: in-flight unit results emerging during DRAIN are discarded silently; rst held multiple cycles restarts DRAIN on release.

Verification
REQ-030 Single req0: a=256'h7dba22bb1548e333af1bacaa0911643b795e5a14641c1e1f6448cbca3ae9f705 -> out_valid0 after LATENCY+2 cycles, out=264'h007dba...f705.
REQ-031 Both valid every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1; results return in the same order, one per cycle, no tag_err.
REQ-032 req1 only, a=256'hdc21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a516967 -> out_valid1 with out=264'h015c21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a51697a; out_valid0 stays 0.
REQ-033 rst pulsed one cycle with 3 ops in flight -> no out_valid for LATENCY cycles, ready low during DRAIN, tag_err stays 0, next request completes normally.
REQ-034 Model injects spurious sq_out_valid with empty tag tail -> tag_err=1 next cycle, no out_valid, remains 1 until rst.
